// File: rtl/mmio_timer_pkg.sv
// Register map offsets, control bit positions and reset constants for the mmio_timer.
package mmio_timer_pkg;

    localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TIMER_CTRL        = 3'd4;
    localparam logic [2:0] TIMER_STATUS      = 3'd5;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_INT_EN = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mmio_timer_byte_merge.sv
// Per-lane mux: each byte takes the new word where its write lane is set, else the old word.
module mmio_timer_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  lanes,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt and atomic hi-word snapshot.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              read,
    input  logic [3:0]        writeb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              external_int
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] snap_q;
    logic [31:0] rd_val;
    logic [2:0]  off;
    logic        enable, tick, pending, ctrl_wr;
    logic [3:0]  be_time_lo, be_time_hi, be_cmp_lo, be_cmp_hi;
    logic        unused_addr;

    assign unused_addr = ^addr[ADDR_W-1:3];
    assign off         = addr[2:0];
    assign enable      = ctrl_q[CTRL_ENABLE];
    assign tick        = enable && (cnt_q == PS_LAST);
    assign mtime_inc   = mtime_q + {63'd0, tick};
    assign pending     = mtime_q >= mtimecmp_q;
    assign ctrl_wr     = sel && (off == TIMER_CTRL) && writeb[0];

    assign be_time_lo = (sel && off == TIMER_MTIME_LO)    ? writeb : 4'b0000;
    assign be_time_hi = (sel && off == TIMER_MTIME_HI)    ? writeb : 4'b0000;
    assign be_cmp_lo  = (sel && off == TIMER_MTIMECMP_LO) ? writeb : 4'b0000;
    assign be_cmp_hi  = (sel && off == TIMER_MTIMECMP_HI) ? writeb : 4'b0000;

    // Writes merge onto the already-incremented time so a same-cycle tick is not lost.
    mmio_timer_byte_merge u_time_lo (
        .old_word (mtime_inc[31:0]),
        .new_word (wdata),
        .lanes    (be_time_lo),
        .merged   (mtime_d[31:0])
    );
    mmio_timer_byte_merge u_time_hi (
        .old_word (mtime_inc[63:32]),
        .new_word (wdata),
        .lanes    (be_time_hi),
        .merged   (mtime_d[63:32])
    );
    mmio_timer_byte_merge u_cmp_lo (
        .old_word (mtimecmp_q[31:0]),
        .new_word (wdata),
        .lanes    (be_cmp_lo),
        .merged   (mtimecmp_d[31:0])
    );
    mmio_timer_byte_merge u_cmp_hi (
        .old_word (mtimecmp_q[63:32]),
        .new_word (wdata),
        .lanes    (be_cmp_hi),
        .merged   (mtimecmp_d[63:32])
    );

    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        if (enable) cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (ctrl_wr) begin
            ctrl_d = wdata[1:0];
            if (!enable && wdata[CTRL_ENABLE]) cnt_d = 16'd0;
        end
    end

    always_comb begin
        case (off)
            TIMER_MTIME_LO:    rd_val = mtime_q[31:0];
            TIMER_MTIME_HI:    rd_val = snap_q;
            TIMER_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            TIMER_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            TIMER_CTRL:        rd_val = {30'd0, ctrl_q};
            TIMER_STATUS:      rd_val = {31'd0, pending};
            default:           rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= MTIMECMP_RST;
            ctrl_q       <= 2'b00;
            cnt_q        <= 16'd0;
            snap_q       <= 32'd0;
            rdata        <= 32'd0;
            external_int <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
            external_int <= pending && ctrl_q[CTRL_INT_EN];
            if (sel && read) begin
                rdata <= rd_val;
                if (off == TIMER_MTIME_LO) snap_q <= mtime_q[63:32];
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with a cycle-level reference model and literal spot checks.
module tb_mmio_timer;

    localparam int unsigned PS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        read;
    logic [3:0]  writeb;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        external_int;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Reference model state
    logic [63:0] m_time, m_cmp;
    logic        m_en, m_ie, m_int;
    int unsigned m_div;
    logic [31:0] m_rd, m_snap;

    mmio_timer #(.PRESCALE(PS), .ADDR_W(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel          (sel),
        .read         (read),
        .writeb       (writeb),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .external_int (external_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mix(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_update();
        logic [63:0] t, c;
        logic        pend, tk, en, ie;
        int unsigned dv;
        logic [31:0] rd, sn;
        if (!rst_n) begin
            m_time = 64'd0; m_cmp = '1; m_en = 0; m_ie = 0; m_div = 0;
            m_rd = 0; m_snap = 0; m_int = 0;
            return;
        end
        pend = (m_time >= m_cmp);
        tk   = m_en && (m_div == PS - 1);
        t    = m_time + (tk ? 64'd1 : 64'd0);
        dv   = m_en ? (tk ? 0 : m_div + 1) : m_div;
        c = m_cmp; en = m_en; ie = m_ie; rd = m_rd; sn = m_snap;
        if (sel) begin
            case (addr[2:0])
                3'd0: t[31:0]  = lane_mix(t[31:0], wdata, writeb);
                3'd1: t[63:32] = lane_mix(t[63:32], wdata, writeb);
                3'd2: c[31:0]  = lane_mix(c[31:0], wdata, writeb);
                3'd3: c[63:32] = lane_mix(c[63:32], wdata, writeb);
                3'd4: if (writeb[0]) begin
                    if (!m_en && wdata[0]) dv = 0;
                    en = wdata[0];
                    ie = wdata[1];
                end
                default: ;
            endcase
            if (read) begin
                case (addr[2:0])
                    3'd0: begin rd = m_time[31:0]; sn = m_time[63:32]; end
                    3'd1: rd = m_snap;
                    3'd2: rd = m_cmp[31:0];
                    3'd3: rd = m_cmp[63:32];
                    3'd4: rd = {30'd0, m_ie, m_en};
                    3'd5: rd = {31'd0, pend};
                    default: rd = 32'd0;
                endcase
            end
        end
        m_int = pend && m_ie;
        m_time = t; m_cmp = c; m_en = en; m_ie = ie; m_div = dv; m_rd = rd; m_snap = sn;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("rdata_vs_model", {32'd0, rdata}, {32'd0, m_rd});
            check("int_vs_model", {63'd0, external_int}, {63'd0, m_int});
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        sel = 0; read = 0; writeb = 4'h0;
        step();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
        sel = 1; read = 0; addr = {8'd0, off}; wdata = d; writeb = be;
        step();
        sel = 0; writeb = 4'h0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
        sel = 1; read = 1; writeb = 4'h0; addr = {8'd0, off};
        step();
        sel = 0; read = 0;
        check(name, {32'd0, rdata}, {32'd0, exp});
    endtask

    initial begin
        int n;
        logic [31:0] rst_vals [8];
        rst_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        rst_n = 0; sel = 0; read = 0; writeb = 0; addr = 0; wdata = 0;
        step();
        started = 1'b1;
        step();
        rst_n = 1;

        // Reset values of every offset
        for (int i = 0; i < 8; i++) rd(3'(i), rst_vals[i], "reset_read");
        check("reset_int", {63'd0, external_int}, 64'd0);

        // Prescaled counting, then freeze
        wr(3'd4, 32'h1, 4'h1);
        for (int i = 0; i < 40; i++) idle();
        rd(3'd0, 32'd10, "count_40");
        wr(3'd4, 32'h0, 4'h1);
        for (int i = 0; i < 20; i++) idle();
        rd(3'd0, 32'd10, "frozen");
        rd(3'd1, 32'd0, "frozen_hi");

        // Carry into hi and snapshot across the carry
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd4, 32'h1, 4'h1);
        idle(); idle();
        rd(3'd0, 32'hFFFF_FFFF, "pre_carry_lo");
        rd(3'd1, 32'd0, "snapshot_hi");
        rd(3'd0, 32'd0, "post_carry_lo");
        rd(3'd1, 32'd1, "post_carry_hi");
        wr(3'd4, 32'h0, 4'h1);

        // Compare interrupt timing and clear by raising mtimecmp
        wr(3'd0, 32'd0, 4'hF);
        wr(3'd1, 32'd0, 4'hF);
        wr(3'd2, 32'h20, 4'hF);
        wr(3'd3, 32'd0, 4'hF);
        wr(3'd4, 32'h3, 4'h1);
        n = 0;
        while (external_int !== 1'b1 && n < 300) begin
            idle();
            n++;
        end
        check("int_latency", 64'(n), 64'd129);
        wr(3'd3, 32'd1, 4'hF);
        check("int_still_high", {63'd0, external_int}, 64'd1);
        idle();
        check("int_cleared", {63'd0, external_int}, 64'd0);
        wr(3'd4, 32'h0, 4'h1);

        // Byte-lane write and write merged with a same-cycle increment
        wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        wr(3'd2, 32'h00AB_0000, 4'b0100);
        rd(3'd2, 32'hFFAB_FFFF, "byte2_only");
        wr(3'd0, 32'h0000_01FF, 4'hF);
        wr(3'd4, 32'h1, 4'h1);
        idle(); idle(); idle();
        wr(3'd0, 32'h0000_0055, 4'b0001);
        wr(3'd4, 32'h0, 4'h1);
        rd(3'd0, 32'h0000_0255, "merge_with_inc");

        // Deselected accesses are ignored
        sel = 0; read = 1; writeb = 4'hF; addr = 11'd3; wdata = 32'd0;
        step(); step(); step();
        read = 0; writeb = 0;
        check("rdata_held", {32'd0, rdata}, 64'h255);
        rd(3'd3, 32'd1, "cmp_hi_untouched");
        rd(3'd2, 32'hFFAB_FFFF, "cmp_lo_untouched");

        // Reset overrides a concurrent write
        rst_n = 0; sel = 1; read = 1; writeb = 4'hF; addr = 11'd2; wdata = 32'h1234;
        step();
        rst_n = 1; sel = 0; read = 0; writeb = 0;
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_int", {63'd0, external_int}, 64'd0);
        for (int i = 0; i < 6; i++) rd(3'(i), rst_vals[i], "post_reset_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
